// File: rtl/arch_state_checker_pkg.sv
// Shared types for the architectural state checker: FSM states and fault source codes.
package arch_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PC   = 2'd1,
        SRC_SNAP = 2'd2,
        SRC_BOTH = 2'd3
    } fault_src_e;

    // Bit 0 flags a PC fault and bit 1 a snapshot fault, so both together encode SRC_BOTH.
    function automatic logic [1:0] fault_src(input logic pc_err, input logic snap_err);
        return {snap_err, pc_err};
    endfunction

endpackage

// File: rtl/chk_masked_cmp.sv
// NCH-wide masked equality compare: mismatch is high if any enabled channel differs.
module chk_masked_cmp #(
    parameter int NCH = 8,
    parameter int DW  = 32
) (
    input  logic [NCH*DW-1:0] a_val,
    input  logic [NCH*DW-1:0] b_val,
    input  logic [NCH-1:0]    mask,
    output logic              mismatch
);

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i] && (a_val[i*DW +: DW] != b_val[i*DW +: DW])) begin
                mismatch = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arch_state_checker.sv
// Run-time checker for the multi-cycle processor: PC-ramp and snapshot checks with sticky faults.
// Optional first-fault log enabled by defining ARCH_CHK_FAULT_LOG_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | counting run cycles, checking PC ramp and snapshots
// DONE  | run finished, done/pass held until start or reset
module arch_state_checker
    import arch_chk_pkg::*;
#(
    parameter int             NCH       = 8,
    parameter int             DW        = 32,
    parameter int             PC_W      = 32,
    parameter logic [PC_W-1:0] PC_BASE  = '0,
    parameter int             PC_STRIDE = 4,
    parameter int             PC_WIN    = 19,
    parameter int             NSNAP     = 2,
    parameter int             RUN_CYC   = 246,
    localparam int            CW        = $clog2(RUN_CYC + 1),
    localparam int            SW        = (NSNAP > 1) ? $clog2(NSNAP) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_W-1:0]     pc,
    input  logic [NCH*DW-1:0]   obs_val,
    input  logic [NCH*DW-1:0]   exp_val,
    input  logic [NCH-1:0]      exp_mask,
    input  logic [NSNAP*CW-1:0] snap_cyc,
    output logic [SW-1:0]       snap_idx,
    output logic [CW-1:0]       cycle_cnt,
    output logic                fault_pc,
    output logic [NSNAP-1:0]    fault_snap,
    output logic                done,
    output logic                pass,
    output logic [CW-1:0]       first_fault_cyc,
    output logic [1:0]          first_fault_src
);

    localparam int IW = $clog2(NSNAP + 1);

    chk_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             fpc_q, fpc_d;
    logic [NSNAP-1:0] fsnap_q, fsnap_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             launch;
    logic             last_cyc;
    logic             pc_err;
    logic [NSNAP-1:0] snap_new;
    logic             cmp_mismatch;
    logic [PC_W-1:0]  pc_exp;
    logic [CW-1:0]    snap_arr [NSNAP];

    chk_masked_cmp #(.NCH(NCH), .DW(DW)) u_cmp (
        .a_val    (obs_val),
        .b_val    (exp_val),
        .mask     (exp_mask),
        .mismatch (cmp_mismatch)
    );

    always_comb begin
        for (int j = 0; j < NSNAP; j++) begin
            snap_arr[j] = snap_cyc[j*CW +: CW];
        end
    end

    assign launch   = (state_q != RUN) && start;
    assign last_cyc = (state_q == RUN) && (int'(cnt_q) == RUN_CYC - 1);
    assign pc_exp   = PC_BASE + PC_W'(cnt_q) * PC_W'(PC_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            fpc_q   <= 1'b0;
            fsnap_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fpc_q   <= fpc_d;
            fsnap_q <= fsnap_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        fpc_d    = fpc_q;
        fsnap_d  = fsnap_q;
        done_d   = done_q;
        pass_d   = pass_q;
        pc_err   = 1'b0;
        snap_new = '0;
        unique case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    idx_d   = '0;
                    fpc_d   = 1'b0;
                    fsnap_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (int'(cnt_q) < PC_WIN) begin
                    pc_err = (pc != pc_exp);
                end
                // Only the pending snapshot is looked at; a missed one costs one cycle each.
                for (int j = 0; j < NSNAP; j++) begin
                    if (IW'(j) == idx_q) begin
                        if (cnt_q == snap_arr[j]) begin
                            snap_new[j] = cmp_mismatch;
                            idx_d       = idx_q + IW'(1);
                        end else if (cnt_q > snap_arr[j]) begin
                            snap_new[j] = 1'b1;
                            idx_d       = idx_q + IW'(1);
                        end
                    end
                end
                if (last_cyc) begin
                    for (int j = 0; j < NSNAP; j++) begin
                        if (IW'(j) >= idx_d) begin
                            snap_new[j] = 1'b1;
                        end
                    end
                end
                fpc_d   = fpc_q | pc_err;
                fsnap_d = fsnap_q | snap_new;
                if (last_cyc) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = ~fpc_d & ~(|fsnap_d);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign snap_idx   = (int'(idx_q) >= NSNAP) ? SW'(NSNAP - 1) : SW'(idx_q);
    assign cycle_cnt  = cnt_q;
    assign fault_pc   = fpc_q;
    assign fault_snap = fsnap_q;
    assign done       = done_q;
    assign pass       = pass_q;

`ifdef ARCH_CHK_FAULT_LOG_EN
    logic [CW-1:0] ffc_q, ffc_d;
    logic [1:0]    ffs_q, ffs_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ffc_q <= '0;
            ffs_q <= SRC_NONE;
        end else begin
            ffc_q <= ffc_d;
            ffs_q <= ffs_d;
        end
    end

    always_comb begin
        ffc_d = ffc_q;
        ffs_d = ffs_q;
        if (launch) begin
            ffc_d = '0;
            ffs_d = SRC_NONE;
        end else if ((state_q == RUN) && (ffs_q == SRC_NONE) && (pc_err || (|snap_new))) begin
            ffc_d = cnt_q;
            ffs_d = fault_src(pc_err, |snap_new);
        end
    end

    assign first_fault_cyc = ffc_q;
    assign first_fault_src = ffs_q;
`else
    assign first_fault_cyc = '0;
    assign first_fault_src = '0;
`endif

endmodule
